// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// Contents:
//   WB_WIDTH / WB_ADDR_W : register data and address widths used by wb_entry_t
//   WE_IDLE / WE_SINGLE / WE_DUAL : register-file write-enable encodings
//   wb_entry_t : one queued execute result (one or two register writes)
package wb_pkg;

  localparam int WB_WIDTH  = 16;
  localparam int WB_ADDR_W = 4;

  localparam logic [1:0] WE_IDLE   = 2'b00;
  localparam logic [1:0] WE_SINGLE = 2'b01;
  localparam logic [1:0] WE_DUAL   = 2'b11;

  typedef struct packed {
    logic                 dual;
    logic [WB_ADDR_W-1:0] addr1;
    logic [WB_ADDR_W-1:0] addr2;
    logic [WB_WIDTH-1:0]  data1;
    logic [WB_WIDTH-1:0]  data2;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of wb_entry_t used by writeback_queue.
// Ports:
//   CLK, RST   : clock (rising edge) and asynchronous active-low reset
//   i_push     : write i_entry at the tail (ignored when full)
//   i_pop      : advance the head (ignored when empty)
//   i_entry    : entry to store
//   o_head     : entry at the head of the queue
//   o_count    : number of valid entries
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_rdPtr    : head index, so a reader can walk entries oldest to newest
//   o_entries  : raw storage for random-read access (validity from o_rdPtr/o_count)
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic             i_pop,
  input  wb_entry_t        i_entry,
  output wb_entry_t        o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W-1:0] o_rdPtr,
  output wb_entry_t        o_entries [DEPTH]
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // Guard against overflow/underflow locally so the pointers can never drift.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read while count marks it valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wrPtr] <= i_entry;
  end

  assign o_head    = r_mem[r_rdPtr];
  assign o_count   = r_count;
  assign o_rdPtr   = r_rdPtr;
  assign o_entries = r_mem;

endmodule

// File: rtl/writeback_queue.sv
// Buffers execute-stage results and retires one entry per cycle into the
// register-file write ports; dual (MUL/DIV) entries write two registers.
// Also offers a combinational bypass lookup over results not yet committed.
// Ports:
//   CLK, RST                      : clock (rising edge), async active-low reset
//   IN_VALID/IN_READY             : execute handshake, transfer = VALID & READY
//   IN_DUAL, IN_ADDR*, IN_DATA*   : result to enqueue (ADDR2/DATA2 used only if dual)
//   HOLD                          : suppress retirement this cycle
//   WRITE_ENABLE                  : 00 idle, 01 single, 11 dual
//   WRITE_ADDRESS*/WRITE_DATA*    : register-file write ports (registered)
//   OP*_ADDRESS                   : operand addresses to look up
//   OP*_HIT/OP*_DATA              : newest pending value for that address (0 if none)
// The wb_entry_t fields are sized by wb_pkg, so WIDTH/ADDR_W must match it.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int WIDTH  = WB_WIDTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_DUAL,
  input  logic [ADDR_W-1:0] IN_ADDR1,
  input  logic [ADDR_W-1:0] IN_ADDR2,
  input  logic [WIDTH-1:0]  IN_DATA1,
  input  logic [WIDTH-1:0]  IN_DATA2,
  input  logic              HOLD,
  output logic [1:0]        WRITE_ENABLE,
  output logic [ADDR_W-1:0] WRITE_ADDRESS1,
  output logic [ADDR_W-1:0] WRITE_ADDRESS2,
  output logic [WIDTH-1:0]  WRITE_DATA1,
  output logic [WIDTH-1:0]  WRITE_DATA2,
  input  logic [ADDR_W-1:0] OP1_ADDRESS,
  input  logic [ADDR_W-1:0] OP2_ADDRESS,
  output logic              OP1_HIT,
  output logic [WIDTH-1:0]  OP1_DATA,
  output logic              OP2_HIT,
  output logic [WIDTH-1:0]  OP2_DATA
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        w_inEntry;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [CNT_W-1:0] w_count;
  logic [PTR_W-1:0] w_rdPtr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  logic [1:0]        r_we;
  logic [ADDR_W-1:0] r_wa1;
  logic [ADDR_W-1:0] r_wa2;
  logic [WIDTH-1:0]  r_wd1;
  logic [WIDTH-1:0]  r_wd2;

  assign w_inEntry = '{dual: IN_DUAL, addr1: IN_ADDR1, addr2: IN_ADDR2,
                       data1: IN_DATA1, data2: IN_DATA2};

  // IN_READY depends only on occupancy; a pop in the same cycle does not open a slot.
  assign IN_READY = ~w_full;
  assign w_push   = IN_VALID & IN_READY;
  assign w_pop    = ~w_empty & ~HOLD;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_entry   (w_inEntry),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_rdPtr   (w_rdPtr),
    .o_entries (w_entries)
  );

  // Write-port register: enable is a one-cycle pulse per pop, while address
  // and data hold their last values so the register file sees stable inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_we  <= WE_IDLE;
      r_wa1 <= '0;
      r_wa2 <= '0;
      r_wd1 <= '0;
      r_wd2 <= '0;
    end else if (w_pop) begin
      r_we  <= w_head.dual ? WE_DUAL : WE_SINGLE;
      r_wa1 <= w_head.addr1;
      r_wa2 <= w_head.addr2;
      r_wd1 <= w_head.data1;
      r_wd2 <= w_head.data2;
    end else begin
      r_we <= WE_IDLE;
    end
  end

  assign WRITE_ENABLE   = r_we;
  assign WRITE_ADDRESS1 = r_wa1;
  assign WRITE_ADDRESS2 = r_wa2;
  assign WRITE_DATA1    = r_wd1;
  assign WRITE_DATA2    = r_wd2;

  // Scan from oldest to newest and let every later match overwrite earlier
  // ones: output register first, then queue head to tail. Within an entry
  // addr2 is checked after addr1 so it wins, matching register-file write order.
  function automatic logic [WIDTH:0] lookup(input logic [ADDR_W-1:0] addr);
    logic             hit;
    logic [WIDTH-1:0] data;
    logic [PTR_W-1:0] idx;
    wb_entry_t        e;
    hit  = 1'b0;
    data = '0;
    if (r_we != WE_IDLE) begin
      if (r_wa1 == addr) begin
        hit  = 1'b1;
        data = r_wd1;
      end
      if (r_we == WE_DUAL && r_wa2 == addr) begin
        hit  = 1'b1;
        data = r_wd2;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = w_rdPtr + PTR_W'(k);
      e   = w_entries[idx];
      if (CNT_W'(k) < w_count) begin
        if (e.addr1 == addr) begin
          hit  = 1'b1;
          data = e.data1;
        end
        if (e.dual && e.addr2 == addr) begin
          hit  = 1'b1;
          data = e.data2;
        end
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {OP1_HIT, OP1_DATA} = lookup(OP1_ADDRESS);
    {OP2_HIT, OP2_DATA} = lookup(OP2_ADDRESS);
  end

endmodule
